// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state encoding, instruction field constants and legality rule
// for the datapath control FSM.
package ctrl_pkg;
    typedef enum logic [2:0] {
        WAIT,
        DECODE,
        WRITE_IMM,
        GET_A,
        GET_B,
        ALU,
        WRITE_REG
    } state_t;
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [1:0] MOV_IMM = 2'b10;
    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;
    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL1 = 2'b01;
    localparam logic [1:0] SH_LSR1 = 2'b10;
    localparam logic [1:0] SH_ASR1 = 2'b11;
    // Every ALU op is defined; only MOV immediate and MOV register exist under OPC_MOV.
    function automatic logic is_legal(input logic [2:0] opcode, input logic [1:0] op);
        return opcode == OPC_ALU || (opcode == OPC_MOV && (op == MOV_IMM || op == MOV_REG));
    endfunction
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational field split of the instruction register.
//   ir     : latched instruction word
//   opcode, op, rn, rd, sh, rm : instruction fields
//   imm    : IR[7:0] sign-extended to DATA_W
//   legal  : instruction is one the controller can execute
module instr_decoder
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8
) (
    input  logic [DATA_W-1:0] ir,
    output logic [2:0]        opcode,
    output logic [1:0]        op,
    output logic [2:0]        rn,
    output logic [2:0]        rd,
    output logic [1:0]        sh,
    output logic [2:0]        rm,
    output logic [DATA_W-1:0] imm,
    output logic              legal
);
    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign imm    = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    assign legal  = is_legal(opcode, op);
endmodule

// File: rtl/datapath_controller.sv
// datapath_controller: instruction-sequencing FSM driving the datapath control lines.
//   clk, reset   : clock, synchronous active-high reset
//   s, in        : start strobe and instruction word, accepted only while waiting
//   w            : high while idle and ready
//   illegal      : one-cycle pulse while decoding an undefined instruction
//   readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, bsel,
//   shift, ALUop : datapath controls (registered, Moore)
//   datapath_in  : sign-extended immediate from the held instruction
module datapath_controller
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic [DATA_W-1:0] in,
    output logic              w,
    output logic              illegal,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic              write,
    output logic              vsel,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [DATA_W-1:0] datapath_in
);
    state_t            state;
    logic [DATA_W-1:0] ir;
    logic [2:0]        opcode, rn, rd, rm;
    logic [1:0]        op, sh;
    logic              legal;
    logic              is_mov, is_cmp;

    instr_decoder #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_dec (
        .ir(ir), .opcode(opcode), .op(op), .rn(rn), .rd(rd), .sh(sh), .rm(rm),
        .imm(datapath_in), .legal(legal)
    );

    assign is_mov = opcode == OPC_MOV;
    assign is_cmp = opcode == OPC_ALU && op == ALU_SUB;
    assign bsel   = 1'b0;

    // Outputs are registered alongside the state: each branch loads the values
    // belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT;
            ir       <= '0;
            w        <= 1'b1;
            illegal  <= 1'b0;
            readnum  <= '0;
            writenum <= '0;
            write    <= 1'b0;
            vsel     <= 1'b0;
            loada    <= 1'b0;
            loadb    <= 1'b0;
            loadc    <= 1'b0;
            loads    <= 1'b0;
            asel     <= 1'b0;
            shift    <= SH_NONE;
            ALUop    <= ALU_ADD;
        end else begin
            w        <= 1'b0;
            illegal  <= 1'b0;
            readnum  <= '0;
            writenum <= '0;
            write    <= 1'b0;
            vsel     <= 1'b0;
            loada    <= 1'b0;
            loadb    <= 1'b0;
            loadc    <= 1'b0;
            loads    <= 1'b0;
            asel     <= 1'b0;
            shift    <= SH_NONE;
            ALUop    <= ALU_ADD;
            unique case (state)
                WAIT: begin
                    if (s) begin
                        ir      <= in;
                        // Judged on the incoming word so the pulse lines up with DECODE.
                        illegal <= !is_legal(in[15:13], in[12:11]);
                        state   <= DECODE;
                    end else begin
                        w <= 1'b1;
                    end
                end
                DECODE: begin
                    if (!legal) begin
                        state <= WAIT;
                        w     <= 1'b1;
                    end else if (is_mov && op == MOV_IMM) begin
                        state    <= WRITE_IMM;
                        writenum <= rn;
                        vsel     <= 1'b1;
                        write    <= 1'b1;
                    end else if (!is_mov && op != ALU_MVN) begin
                        state   <= GET_A;
                        readnum <= rn;
                        loada   <= 1'b1;
                    end else begin
                        state   <= GET_B;
                        readnum <= rm;
                        loadb   <= 1'b1;
                    end
                end
                GET_A: begin
                    state   <= GET_B;
                    readnum <= rm;
                    loadb   <= 1'b1;
                end
                GET_B: begin
                    state <= ALU;
                    shift <= sh;
                    asel  <= is_mov;
                    ALUop <= is_mov ? ALU_ADD : op;
                    loads <= is_cmp;
                    loadc <= !is_cmp;
                end
                ALU: begin
                    if (is_cmp) begin
                        state <= WAIT;
                        w     <= 1'b1;
                    end else begin
                        state    <= WRITE_REG;
                        writenum <= rd;
                        write    <= 1'b1;
                    end
                end
                default: begin
                    state <= WAIT;
                    w     <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_datapath_controller.sv
// tb_datapath_controller: randomized and directed checks of the controller
// against a per-instruction model of the expected control sequence.
module tb_datapath_controller;
    typedef struct packed {
        logic       w;
        logic       illegal;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
    } ctl_t;

    logic        clk, reset, s;
    logic [15:0] in;
    logic        w, illegal, write, vsel, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;
    int          checks = 0;
    int          errors = 0;
    ctl_t        exp_q[$];

    datapath_controller dut (
        .clk(clk), .reset(reset), .s(s), .in(in), .w(w), .illegal(illegal),
        .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
        .datapath_in(datapath_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic ctl_t obs();
        ctl_t c;
        c.w = w; c.illegal = illegal; c.readnum = readnum; c.writenum = writenum;
        c.write = write; c.vsel = vsel; c.loada = loada; c.loadb = loadb;
        c.loadc = loadc; c.loads = loads; c.asel = asel; c.bsel = bsel;
        c.shift = shift; c.aluop = ALUop;
        return c;
    endfunction

    function automatic ctl_t idle();
        ctl_t c = '0;
        c.w = 1'b1;
        return c;
    endfunction

    function automatic logic [15:0] sext(input logic [15:0] i);
        return {{8{i[7]}}, i[7:0]};
    endfunction

    // Edges from acceptance until w returns, per instruction class.
    function automatic int latency(input logic [15:0] i);
        if (i[15:13] == 3'b110 && i[12:11] == 2'b10) return 2;
        if (i[15:13] == 3'b110 && i[12:11] == 2'b00) return 4;
        if (i[15:13] == 3'b101) return (i[12:11] == 2'b00 || i[12:11] == 2'b10) ? 5 : 4;
        return 1;
    endfunction

    // Expected control vector for each cycle after acceptance, up to (not including) the return to idle.
    function automatic void build(input logic [15:0] i);
        ctl_t       c;
        logic [2:0] opc = i[15:13];
        logic [1:0] op = i[12:11];
        bit legal = opc == 3'b101 || (opc == 3'b110 && (op == 2'b00 || op == 2'b10));
        bit movreg = opc == 3'b110 && op == 2'b00;
        bit cmp = opc == 3'b101 && op == 2'b01;
        exp_q.delete();
        c = '0;
        c.illegal = !legal;
        exp_q.push_back(c);
        if (!legal) return;
        if (opc == 3'b110 && op == 2'b10) begin
            c = '0; c.writenum = i[10:8]; c.vsel = 1'b1; c.write = 1'b1;
            exp_q.push_back(c);
            return;
        end
        if (opc == 3'b101 && op != 2'b11) begin
            c = '0; c.readnum = i[10:8]; c.loada = 1'b1;
            exp_q.push_back(c);
        end
        c = '0; c.readnum = i[2:0]; c.loadb = 1'b1;
        exp_q.push_back(c);
        c = '0; c.shift = i[4:3]; c.asel = movreg; c.aluop = movreg ? 2'b00 : op;
        c.loads = cmp; c.loadc = !cmp;
        exp_q.push_back(c);
        if (!cmp) begin
            c = '0; c.writenum = i[7:5]; c.write = 1'b1;
            exp_q.push_back(c);
        end
    endfunction

    // Issues one instruction at a negedge and follows it back to idle; returns at the idle negedge.
    task automatic run_instr(input string name, input logic [15:0] i, input bit keep_s, input bit poke_s);
        ctl_t e;
        int   lat_obs = -1;
        build(i);
        in = i;
        s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 12; j++) begin
            e = (j < exp_q.size()) ? exp_q[j] : idle();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL %s ctl cycle %0d: got %h want %h", name, j, obs(), e);
            end
            checks++;
            if (datapath_in !== sext(i)) begin
                errors++;
                $display("FAIL %s datapath_in cycle %0d: got %h want %h", name, j, datapath_in, sext(i));
            end
            if (w === 1'b1) begin
                lat_obs = j;
                break;
            end
            in = 16'($urandom);
            s = poke_s ? 1'($urandom_range(0, 1)) : keep_s;
            @(negedge clk);
        end
        s = keep_s;
        checks++;
        if (lat_obs != latency(i)) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat_obs, latency(i));
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; s = 1'b0; in = 16'hFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs() !== idle()) begin
            errors++;
            $display("FAIL reset ctl: got %h want %h", obs(), idle());
        end
        checks++;
        if (datapath_in !== 16'h0000) begin
            errors++;
            $display("FAIL reset datapath_in: got %h want 0000", datapath_in);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_instr;
        ctl_t e = '0;
        in = 16'hA148; s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s = 1'b0;
        @(negedge clk);
        e.readnum = 3'd1; e.loada = 1'b1;
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL reset_mid get_a: got %h want %h", obs(), e);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (obs() !== idle()) begin
            errors++;
            $display("FAIL reset_mid ctl: got %h want %h", obs(), idle());
        end
        checks++;
        if (datapath_in !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid datapath_in: got %h want 0000", datapath_in);
        end
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (write !== 1'b0 || w !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid idle: write %b w %b want 0 1", write, w);
            end
        end
    endtask

    task automatic test_mov_imm;
        run_instr("mov_r0_7", 16'hD007, 1'b0, 1'b0);
        run_instr("mov_r5_neg1", 16'hD5FF, 1'b0, 1'b0);
        checks++;
        if (datapath_in !== 16'hFFFF) begin
            errors++;
            $display("FAIL mov_r5_neg1 hold: got %h want ffff", datapath_in);
        end
    endtask

    task automatic test_add;
        run_instr("add_r2_r1_r0_lsl", 16'hA148, 1'b0, 1'b0);
    endtask

    task automatic test_cmp;
        run_instr("cmp_r0_r1", 16'hA801, 1'b0, 1'b0);
    endtask

    task automatic test_mvn;
        run_instr("mvn_r3_r0", 16'hB860, 1'b0, 1'b0);
        run_instr("mov_reg_r1_r4_asr", 16'hC03C, 1'b0, 1'b0);
    endtask

    task automatic test_illegal;
        run_instr("illegal_e000", 16'hE000, 1'b0, 1'b0);
        run_instr("illegal_mov01", 16'hC800, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse_width: got %b want 0", illegal);
        end
    endtask

    task automatic test_back_to_back;
        run_instr("b2b_first", 16'hD007, 1'b1, 1'b0);
        run_instr("b2b_second", 16'hD007, 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignore;
        run_instr("busy_add", 16'hA148, 1'b0, 1'b1);
        run_instr("busy_cmp", 16'hA801, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        logic [15:0] i;
        int          r;
        for (int n = 0; n < 40; n++) begin
            i = 16'($urandom);
            r = $urandom_range(0, 5);
            if (r < 2) i[15:13] = 3'b101;
            else if (r < 4) i[15:13] = 3'b110;
            run_instr("random", i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        s = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; s = 1'b0; in = '0;
        test_reset();
        test_reset_mid_instr();
        test_mov_imm();
        test_add();
        test_cmp();
        test_mvn();
        test_illegal();
        test_back_to_back();
        test_busy_ignore();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/datapath_controller.md
Name: datapath_controller

Overview:
Control FSM that drives the `datapath` register-file/ALU block from the control side.
- Latches a 16-bit instruction on a start handshake and decodes opcode/op fields.
- Sequences the datapath control lines cycle by cycle (read, load A/B, ALU, writeback).
- Raises `w` when idle and ready for the next instruction.
- Sits between instruction source (switches/bench) and `datapath`; its outputs connect port-for-port to `datapath` inputs.

Parameters:
DATA_W, 16, datapath word width and instruction width
IMM_W, 8, immediate field width, sign-extended to DATA_W

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high; sampled on rising clk
s  input  1  start; sampled only in WAIT
in  input  DATA_W  instruction word; captured into IR when s accepted
w  output  1  1 exactly when state==WAIT
illegal  output  1  one-cycle pulse on undefined instruction
readnum  output  3  register read select
writenum  output  3  register write select
write  output  1  register-file write enable
vsel  output  1  1: writeback datapath_in; 0: writeback C
loada, loadb, loadc, loads  output  1 each  datapath register enables
asel  output  1  1: ALU A operand forced to 0
bsel  output  1  1: ALU B operand from datapath_in
shift  output  2  shifter op (00 none, 01 LSL1, 10 LSR1, 11 ASR1)
ALUop  output  2  00 add, 01 sub, 10 and, 11 not-B
datapath_in  output  DATA_W  sign-extended IR[7:0]; always driven

Behaviour:
- Clock/reset: one clock, `clk`; reset is synchronous, active-high, named `reset`.
- Reset (wins over everything, including mid-instruction):
  - state=WAIT, IR=0.
  - Outputs: w=1, illegal=0, all enables 0, readnum=writenum=0, shift=ALUop=00, datapath_in=0.
- IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0], imm8=IR[7:0].
- Moore outputs; every control output defaults to 0 in every state unless listed below.
- WAIT:
  - w=1.
  - If s=1 at edge: IR<=in, next state DECODE. Otherwise stay.
  - s is ignored in every other state; `in` may change freely after capture.
- DECODE: all controls 0. Next state:
  - 110/10 -> WRITE_IMM
  - 110/00 -> GET_B
  - 101/11 -> GET_B
  - 101/00, 101/01, 101/10 -> GET_A
  - anything else -> WAIT, with illegal=1 during DECODE
- WRITE_IMM: writenum=Rn, vsel=1, write=1 -> WAIT.
- GET_A: readnum=Rn, loada=1 -> GET_B.
- GET_B: readnum=Rm, loadb=1 -> ALU.
- ALU: shift=sh, bsel=0.
  - MOV reg: asel=1, ALUop=00.
  - ADD/AND/MVN: asel=0, ALUop=op.
  - CMP: ALUop=01, loads=1, loadc=0 -> WAIT.
  - All others: loadc=1 -> WRITE_REG.
- WRITE_REG: writenum=Rd, vsel=0, write=1 -> WAIT.
- Latency, counted in edges from the accepting edge to w=1:
  - MOV imm: 2
  - illegal: 1
  - MOV reg / MVN: 4
  - CMP: 4
  - ADD/AND: 5
- Back-to-back: s held high re-triggers on the first WAIT edge, so w is high for exactly one cycle.
- The datapath's register file, A/B/C and status registers are owned by `datapath`; this block holds only state and IR.

Decomposition:
- Package `ctrl_pkg`:
  - state encoding (WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG)
  - opcode constants (OPC_MOV=110, OPC_ALU=101)
  - op constants (MOV_IMM=10, MOV_REG=00)
  - ALUop constants (ADD, SUB, AND, MVN)
  - shift constants
- Sub-module `instr_decoder`: combinational field extraction, imm8 sign-extension, legality flag.
- FSM and IR live in `datapath_controller`.

Test Plan:
1. Reset mid-instruction: assert reset in GET_A of an ADD -> next edge state=WAIT, w=1, all enables 0, datapath_in=0000. No write pulse is ever seen.
2. MOV R0,#7:
   - Stimulus: in=16'hD007, s=1 one cycle.
   - Required: DECODE, then one cycle write=1, vsel=1, writenum=0, datapath_in=0007; w=1 two edges after capture.
   - Also in=16'hD5FF gives datapath_in=FFFF, writenum=5.
3. ADD R2,R1,R0,LSL#1:
   - Stimulus: in=16'hA148.
   - Required sequence:
     - loada with readnum=1
     - loadb with readnum=0
     - loadc, asel=0, shift=01, ALUop=00
     - write with writenum=2, vsel=0
     - w=1 at edge 5
   - With `datapath` attached (R0=7, R1=2): R2=16'd16.
4. CMP R0,R1: in=16'hA801 -> loada (readnum 0), loadb (readnum 1), then ALUop=01 with loads=1, loadc=0; write stays 0 throughout; w at edge 4.
5. MVN R3,R0: in=16'hB860 -> no loada; loadb readnum=0; ALUop=11 with loadc; write writenum=3.
6. Illegal/handshake:
   - in=16'hE000 -> illegal=1 for one cycle, no enables asserted, w at edge 1.
   - s held high over two D007 instructions -> w is high for exactly one cycle between them.
   - s pulsed while busy -> ignored.
